// File: rtl/shift_sequencer_if.sv
// Handshake and data bundle between a shift_sequencer and whatever drives it.
// The abort wire is only present when SHIFT_SEQ_ABORT_EN is defined.
interface shift_sequencer_if #(parameter int CNT_W = 4) ();
  logic             start;
  logic [15:0]      in_data;
  logic [1:0]       op;
  logic [CNT_W-1:0] count;
  logic             ready;
  logic             busy;
  logic             done;
  logic [15:0]      result;
`ifdef SHIFT_SEQ_ABORT_EN
  logic             abort;
`endif

  modport master (
`ifdef SHIFT_SEQ_ABORT_EN
    output abort,
`endif
    output start, in_data, op, count,
    input  ready, busy, done, result
  );

  modport slave (
`ifdef SHIFT_SEQ_ABORT_EN
    input  abort,
`endif
    input  start, in_data, op, count,
    output ready, busy, done, result
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle 16-bit shifter: one 1-bit step of the captured op per clock for count steps.
// Define SHIFT_SEQ_ABORT_EN to add an abort input that drops an in-flight shift back to IDLE.
//
// state | meaning
// IDLE  | ready, waiting for start; acc holds the last result
// SHIFT | applying one step per edge, rem steps left
// DONE  | one-cycle completion pulse, returns to IDLE
module shift_sequencer #(
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  shift_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [15:0]      acc;
  logic [CNT_W-1:0] rem;
  logic [1:0]       op_r;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;

  function automatic logic [15:0] step(input logic [15:0] a, input logic [1:0] o);
    logic [15:0] r;
    r = a;
    unique case (o)
      2'b01:   r = {a[14:0], 1'b0};
      2'b10:   r = {1'b0, a[15:1]};
      2'b11:   r = {a[15], a[15:1]};
      default: r = a;
    endcase
    return r;
  endfunction

  // Flags are updated with the state so they are always a registered decode of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= 16'h0000;
      rem     <= '0;
      op_r    <= 2'b00;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            acc     <= bus.in_data;
            rem     <= bus.count;
            op_r    <= bus.op;
            ready_q <= 1'b0;
            if (bus.count != '0) begin
              state  <= SHIFT;
              busy_q <= 1'b1;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
`ifdef SHIFT_SEQ_ABORT_EN
          if (bus.abort) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else
`endif
          begin
            acc <= step(acc, op_r);
            rem <= rem - CNT_W'(1);
            if (rem == CNT_W'(1)) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready  = ready_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = acc;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: elapsed-time reference model checked every
// cycle, directed cases with literal expectations, then randomized traffic.
module tb_shift_sequencer;
  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;
  logic abort_v;
  int   errors;
  int   checks;

  shift_sequencer_if #(.CNT_W(CNT_W)) bus ();

`ifdef SHIFT_SEQ_ABORT_EN
  assign bus.abort = abort_v;
`endif

  shift_sequencer #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Result of shifting d by k one-bit steps of op o, computed in one go.
  function automatic logic [15:0] sh(input logic [15:0] d, input logic [1:0] o, input int k);
    case (o)
      2'b01:   return d << k;
      2'b10:   return d >> k;
      2'b11:   return 16'($signed(d) >>> k);
      default: return d;
    endcase
  endfunction

  // Reference: an accepted op is described by its operands and the edges elapsed since accept.
  bit          m_active;
  logic [15:0] m_in;
  logic [1:0]  m_op;
  int          m_n;
  int          m_e;
  logic [15:0] m_idle_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active   = 1'b0;
      m_idle_res = 16'h0000;
    end else if (m_active) begin
      if (m_e < m_n && abort_v === 1'b1) begin
`ifdef SHIFT_SEQ_ABORT_EN
        m_active   = 1'b0;
        m_idle_res = sh(m_in, m_op, m_e);
`else
        m_e++;
`endif
      end else begin
        m_e++;
        if (m_e > m_n) begin
          m_active   = 1'b0;
          m_idle_res = sh(m_in, m_op, m_n);
        end
      end
    end else if (bus.start) begin
      m_active = 1'b1;
      m_in     = bus.in_data;
      m_op     = bus.op;
      m_n      = int'(bus.count);
      m_e      = 0;
    end
  end

  logic [18:0] exp_v;
  logic [18:0] act_v;
  always @(negedge clk) begin
    if (m_active)
      exp_v = {1'b0, (m_e < m_n), (m_e == m_n), sh(m_in, m_op, m_e)};
    else
      exp_v = {1'b1, 1'b0, 1'b0, m_idle_res};
    act_v = {bus.ready, bus.busy, bus.done, bus.result};
    check("cycle ready/busy/done/result", 32'(act_v), 32'(exp_v));
  end

  // Call just after a negedge with the DUT idle; returns one negedge after done is seen.
  task automatic run_op(input logic [15:0] d, input logic [1:0] o, input int n, input int poke,
                        output int lat, output int bcnt, output logic [15:0] res);
    bus.start   = 1'b1;
    bus.in_data = d;
    bus.op      = o;
    bus.count   = CNT_W'(n);
    lat  = 0;
    bcnt = 0;
    do begin
      @(negedge clk);
      lat++;
      bus.start   = (lat == poke);
      bus.in_data = (lat == poke) ? 16'hFFFF : 16'($urandom);
      bus.op      = 2'($urandom);
      bus.count   = CNT_W'($urandom);
      if (bus.busy) bcnt++;
    end while (!bus.done && lat < 64);
    bus.start = 1'b0;
    res = bus.result;
    check("op completes within bound", 32'(lat < 64), 32'd1);
    @(negedge clk);
  endtask

  int          lat;
  int          bc;
  logic [15:0] r;
  bit          saw_done;

  initial begin
    errors = 0;
    checks = 0;
    abort_v = 1'b0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.in_data = 16'h0;
    bus.op = 2'b00;
    bus.count = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset ready", 32'(bus.ready), 32'd1);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset result", 32'(bus.result), 32'h0);
    rst_n = 1'b1;

    run_op(16'h8001, 2'b01, 3, 0, lat, bc, r);
    check("lsl3 latency", 32'(lat), 32'd4);
    check("lsl3 busy cycles", 32'(bc), 32'd3);
    check("lsl3 result", 32'(r), 32'h0008);

    run_op(16'h8000, 2'b11, 4, 0, lat, bc, r);
    check("asr4 latency", 32'(lat), 32'd5);
    check("asr4 result", 32'(r), 32'hF800);

    run_op(16'h8000, 2'b10, 15, 0, lat, bc, r);
    check("lsr15 latency", 32'(lat), 32'd16);
    check("lsr15 result", 32'(r), 32'h0001);

    run_op(16'h1234, 2'b01, 0, 0, lat, bc, r);
    check("count0 latency", 32'(lat), 32'd1);
    check("count0 busy cycles", 32'(bc), 32'd0);
    check("count0 result", 32'(r), 32'h1234);

    run_op(16'h0001, 2'b01, 5, 2, lat, bc, r);
    check("start-while-busy latency", 32'(lat), 32'd6);
    check("start-while-busy result", 32'(r), 32'h0020);

    // Asynchronous reset in the middle of an 8-step shift.
    bus.start = 1'b1; bus.in_data = 16'h00FF; bus.op = 2'b01; bus.count = CNT_W'(8);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset ready", 32'(bus.ready), 32'd1);
    check("async reset result", 32'(bus.result), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h0003, 2'b10, 1, 0, lat, bc, r);
    check("post-reset latency", 32'(lat), 32'd2);
    check("post-reset result", 32'(r), 32'h0001);

`ifdef SHIFT_SEQ_ABORT_EN
    bus.start = 1'b1; bus.in_data = 16'h0001; bus.op = 2'b01; bus.count = CNT_W'(10);
    saw_done = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) saw_done = 1'b1;
      if (i == 4) abort_v = 1'b1;
    end
    @(negedge clk);
    abort_v = 1'b0;
    if (bus.done) saw_done = 1'b1;
    check("abort ready", 32'(bus.ready), 32'd1);
    check("abort result", 32'(bus.result), 32'h0008);
    check("abort no done", 32'(saw_done), 32'd0);
`endif

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      bus.start   = ($urandom_range(0, 3) == 0);
      bus.in_data = 16'($urandom);
      bus.op      = 2'($urandom);
      bus.count   = CNT_W'($urandom);
`ifdef SHIFT_SEQ_ABORT_EN
      abort_v     = ($urandom_range(0, 15) == 0);
`endif
    end
    bus.start = 1'b0;
    abort_v = 1'b0;
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter CNT_W, default 4, SHALL set the width of the shift-count input (maximum count 2^CNT_W-1).
REQ-002 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 start  input  1  SHALL be the request strobe; sampled only when ready=1.
REQ-005 in_data  input  16  SHALL be the operand, captured on an accepted start.
REQ-006 op  input  2  SHALL be the per-step shift code, captured on accept: 00 pass, 01 left logical, 10 right logical, 11 right arithmetic (MSB replicated).
REQ-007 count  input  CNT_W  SHALL be the number of 1-bit steps, captured on accept.
REQ-008 ready  output  1  SHALL be high exactly when state=IDLE.
REQ-009 busy  output  1  SHALL be high exactly when state=SHIFT.
REQ-010 done  output  1  SHALL be a one-cycle pulse, high exactly when state=DONE.
REQ-011 result  output  16  SHALL be the registered accumulator.
REQ-012 abort  input  1  SHALL exist only when SHIFT_SEQ_ABORT_EN is defined.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT, DONE; no other reachable states.
REQ-014 Accept: IDLE and start=1 at an edge SHALL load acc<=in_data, rem<=count, op_r<=op; next state SHIFT if count!=0, else DONE.
REQ-015 IDLE with start=0 SHALL hold all registers.
REQ-016 SHIFT: each edge SHALL apply one 1-bit step of op_r to acc (LSB fill 0 for 01; MSB fill 0 for 10; MSB fill acc[15] for 11; unchanged for 00) and decrement rem.
REQ-017 SHIFT with rem=1 SHALL transition to DONE at that edge (after the final step).
REQ-018 Latency: done SHALL go high N+1 cycles after the accepting edge for count=N (1 cycle for N=0).
REQ-019 DONE SHALL transition unconditionally to IDLE at the next edge; start during DONE is ignored.
REQ-020 start while busy=1 SHALL be ignored and SHALL NOT alter in-flight acc, rem or op_r.
REQ-021 result SHALL equal acc at all times; final value SHALL hold from DONE until the next accepted start.
REQ-022 Bits shifted out SHALL be discarded; no carry/flag output.
REQ-023 Inputs in_data, op, count SHALL be don't-care except at an accepting edge.

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE, acc=0x0000, rem=0, op_r=00, independent of clk.
REQ-025 During reset outputs SHALL be ready=1, busy=0, done=0, result=0x0000.
REQ-026 Reset mid-operation SHALL abandon the operation with no done pulse; first accept possible at the first edge after rst_n rises.

Configuration
REQ-027 Macro SHIFT_SEQ_ABORT_EN defined: abort=1 at an edge in SHIFT SHALL transition to IDLE, hold acc at its partially shifted value, produce no done pulse; abort ignored in IDLE/DONE; abort has priority over REQ-017.
REQ-028 Macro SHIFT_SEQ_ABORT_EN undefined: no abort port; every accepted operation SHALL run to DONE.

Verification
REQ-029 in_data=0x8001, op=01, count=3 accepted -> busy 3 cycles, done on 4th cycle, result=0x0008.
REQ-030 in_data=0x8000, op=11, count=4 -> result=0xF800 with done 5 cycles after accept; op=10 count=15 on 0x8000 -> 0x0001 after 16 cycles.
REQ-031 in_data=0x1234, op=01, count=0 -> no busy, done next cycle, result=0x1234.
REQ-032 Accept op=01 count=5 on 0x0001, pulse start with in_data=0xFFFF during SHIFT -> ignored, result=0x0020.
REQ-033 Drop rst_n mid-SHIFT (count=8) -> result=0x0000, ready=1 immediately, no done; new op after release completes normally.
REQ-034 With SHIFT_SEQ_ABORT_EN: 0x0001 op=01 count=10, abort after 3 steps -> IDLE, result=0x0008, no done pulse.
